// File: rtl/ysyx_24110015_arbiter_if.sv
// axi_lite_if: 32-bit AXI-lite bundle shared by the IFU, LSU and memory ports
interface axi_lite_if;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  modport master (
    output araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input  araddr, arsize, arvalid, rready, awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_24110015_arbiter.sv
// ysyx_24110015_arbiter: fixed-priority (LSU over IFU) AXI-lite arbiter, one transaction in flight
module ysyx_24110015_arbiter (
  input  logic       clk,
  input  logic       rst,
  axi_lite_if.slave  ifu,
  axi_lite_if.slave  lsu,
  axi_lite_if.master mem
);
  typedef enum logic [1:0] {IDLE, RD_IFU, RD_LSU, WR_LSU} st_e;
  st_e  st_q, st_d;
  logic ar_done_q, ar_done_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic rd_i, rd_l, wr_l, ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic unused_ifu_wr;
  assign rd_i = st_q == RD_IFU;
  assign rd_l = st_q == RD_LSU;
  assign wr_l = st_q == WR_LSU;
  assign mem.araddr  = rd_i ? ifu.araddr : rd_l ? lsu.araddr : '0;
  assign mem.arsize  = rd_i ? ifu.arsize : rd_l ? lsu.arsize : '0;
  assign mem.arvalid = ((rd_i & ifu.arvalid) | (rd_l & lsu.arvalid)) & ~ar_done_q;
  assign mem.rready  = (rd_i & ifu.rready) | (rd_l & lsu.rready);
  assign mem.awaddr  = wr_l ? lsu.awaddr : '0;
  assign mem.awsize  = wr_l ? lsu.awsize : '0;
  assign mem.awvalid = wr_l & lsu.awvalid & ~aw_done_q;
  assign mem.wdata   = wr_l ? lsu.wdata : '0;
  assign mem.wstrb   = wr_l ? lsu.wstrb : '0;
  assign mem.wvalid  = wr_l & lsu.wvalid & ~w_done_q;
  assign mem.bready  = wr_l & lsu.bready;
  assign ifu.arready = rd_i & mem.arready & ~ar_done_q;
  assign ifu.rvalid  = rd_i & mem.rvalid;
  assign ifu.rdata   = rd_i ? mem.rdata : '0;
  assign ifu.rresp   = rd_i ? mem.rresp : '0;
  assign ifu.awready = 1'b0;
  assign ifu.wready  = 1'b0;
  assign ifu.bvalid  = 1'b0;
  assign ifu.bresp   = '0;
  assign lsu.arready = rd_l & mem.arready & ~ar_done_q;
  assign lsu.rvalid  = rd_l & mem.rvalid;
  assign lsu.rdata   = rd_l ? mem.rdata : '0;
  assign lsu.rresp   = rd_l ? mem.rresp : '0;
  assign lsu.awready = wr_l & mem.awready & ~aw_done_q;
  assign lsu.wready  = wr_l & mem.wready & ~w_done_q;
  assign lsu.bvalid  = wr_l & mem.bvalid;
  assign lsu.bresp   = wr_l ? mem.bresp : '0;
  assign ar_hs = mem.arvalid & mem.arready;
  assign r_hs  = mem.rvalid & mem.rready;
  assign aw_hs = mem.awvalid & mem.awready;
  assign w_hs  = mem.wvalid & mem.wready;
  assign b_hs  = mem.bvalid & mem.bready;
  // the IFU write channels are deliberately ignored
  assign unused_ifu_wr = ^{ifu.awaddr, ifu.awsize, ifu.awvalid, ifu.wdata, ifu.wstrb, ifu.wvalid, ifu.bready};
  // grant decision in IDLE, release on the closing response handshake
  always_comb begin
    st_d = st_q == IDLE ? (lsu.arvalid ? RD_LSU : (lsu.awvalid | lsu.wvalid) ? WR_LSU : ifu.arvalid ? RD_IFU : IDLE)
         : (r_hs | b_hs) ? IDLE : st_q;
    ar_done_d = (ar_done_q | ar_hs) & ~r_hs;
    aw_done_d = (aw_done_q | aw_hs) & ~b_hs;
    w_done_d  = (w_done_q | w_hs) & ~b_hs;
  end
  // state and per-channel done flags, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q      <= IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      st_q      <= st_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule
